apb_master: RTL and testbench

- APB requester (bridge) that drives the peripheral-side APB bus (psel/penable/paddr/pwdata/pwrite) from a simple valid/ready command port.
- Returns read data and error status on a single-cycle response strobe.
- Sits between the internal controller and APB completers mapped at base 0x80000000.
- One transfer in flight at a time.

---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_timeout_cnt.sv | 39 +++
 rtl/apb_master.sv | 158 +++++++++++++++
 tb/tb_apb_master.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB requester:
//   - apb_state_e   : requester FSM encoding (IDLE = 0, SETUP = 1, ACCESS = 2)
//   - APB_BASE_ADDR : base of the APB completer window
//   - APB_ADDR_W_DEF / APB_DATA_W_DEF : width defaults taken from the
//     `addrWidth / `dataWidth macros (both default to 32 when not predefined)
// -----------------------------------------------------------------------------
`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef dataWidth
`define dataWidth 32
`endif

package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [31:0] APB_BASE_ADDR  = 32'h8000_0000;
  localparam int          APB_ADDR_W_DEF = `addrWidth;
  localparam int          APB_DATA_W_DEF = `dataWidth;

endpackage

// File: rtl/apb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// apb_timeout_cnt
// Wait-state watchdog for the ACCESS phase. Only instantiated when the
// APB_MASTER_TIMEOUT_EN macro is defined.
// Ports:
//   clk_i      : clock, posedge
//   reset_i    : synchronous active-high reset
//   clear_i    : zero the count (asserted in the cycle before ACCESS)
//   enable_i   : count this cycle (ACCESS with pready low)
//   expired_o  : this enabled cycle brings the count to LIMIT
// -----------------------------------------------------------------------------
module apb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // At least 8 bits, wider if LIMIT needs it.
  localparam int CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The count "reaches" LIMIT on the enabled cycle that would increment it
  // from LIMIT-1, so the transfer is aborted after LIMIT wait cycles.
  assign expired_o = enable_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// APB requester: accepts one command at a time on a valid/ready port, runs a
// SETUP + ACCESS transfer on the APB bus and returns a one-cycle response.
//
// Handshake: a command transfers at a posedge where cmd_valid && cmd_ready.
// cmd_ready depends only on state (IDLE and not in reset). rsp_valid is a
// one-cycle strobe with no backpressure; it coincides with IDLE so the next
// command may be accepted in the same cycle.
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN -- aborts an ACCESS phase
// that waits TIMEOUT_CYCLES cycles with pready low (rsp_err = rsp_timeout = 1).
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command port
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout         : response port
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr : APB bus
//   dbg_state                       : current FSM state (apb_state_e encoding)
// -----------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W_DEF,
  parameter int DATA_W         = APB_DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [1:0]        dbg_state
);

  apb_state_e        state_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;
  logic              tmo_expired;

`ifdef APB_MASTER_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_enable;

  // Clearing during SETUP leaves the count at zero on entry to ACCESS.
  assign tmo_clear  = (state_q == ST_SETUP);
  assign tmo_enable = (state_q == ST_ACCESS) && !pready;

  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i     (clk),
    .reset_i   (reset),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_enable),
    .expired_o (tmo_expired)
  );

  assign rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (^TIMEOUT_CYCLES) ^ rsp_timeout_q;
  assign tmo_expired        = 1'b0;
  assign rsp_timeout        = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // cmd_ready is 1 here, so cmd_valid alone means acceptance.
          if (cmd_valid) begin
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            pwrite_q <= cmd_write;
            psel_q   <= 1'b1;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready wins over a watchdog expiry in the same cycle.
          if (pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            rsp_err_q     <= pslverr;
            rsp_timeout_q <= 1'b0;
            state_q       <= ST_IDLE;
          end else if (tmo_expired) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Self-checking bench for apb_master. A completer model answers ACCESS
// phases with a per-transfer wait count, read data and error flag; expected
// responses and bus contents are queued when a command is accepted and
// compared when the DUT drives the bus / raises rsp_valid.
// -----------------------------------------------------------------------------
module tb_apb_master;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 4;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    int            lat;
    int            acc;
  } exp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_t;

  typedef struct {
    int            waits;
    logic [DW-1:0] rdata;
    logic          err;
  } comp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;
  logic [1:0]    dbg_state;

  exp_t  exp_q[$];
  bus_t  bus_q[$];
  comp_t comp_q[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int low_run = 100;
  int last_gap = -1;
  int last_rsp_edge = -1;
  logic prev_psel = 1'b0;
  int wcnt = 0;

  apb_master #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got cycle budget exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- completer model ----------------
  initial begin
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && psel && penable && comp_q.size() > 0) begin
        if (wcnt < comp_q[0].waits) begin
          pready  = 1'b0;
          prdata  = $urandom;
          pslverr = 1'($urandom_range(0, 1));
          wcnt++;
        end else begin
          pready  = 1'b1;
          prdata  = comp_q[0].rdata;
          pslverr = comp_q[0].err;
        end
      end else begin
        // Noise outside ACCESS must be ignored by the requester.
        pready  = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
        wcnt    = 0;
      end
    end
  end

  // ---------------- bus / response monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (psel) begin
        if (bus_q.size() == 0) begin
          check("bus_unexpected_psel", 64'(psel), 64'd0);
        end else begin
          check("paddr", 64'(paddr), 64'(bus_q[0].addr));
          check("pwrite", 64'(pwrite), 64'(bus_q[0].wr));
          check("pwdata", 64'(pwdata), 64'(bus_q[0].wdata));
          check("penable_phase", 64'(penable), 64'(prev_psel));
        end
        if (!prev_psel) begin
          last_gap = low_run;
          low_run  = 0;
        end
      end else begin
        low_run++;
        check("penable_without_psel", 64'(penable), 64'd0);
      end
      if (rsp_valid) begin
        last_rsp_edge = cyc + 1;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
          if (e.lat >= 0) check("rsp_latency", 64'(cyc + 1 - e.acc), 64'(e.lat));
          if (bus_q.size() > 0) void'(bus_q.pop_front());
          if (comp_q.size() > 0) void'(comp_q.pop_front());
        end
      end
    end
    prev_psel = reset ? 1'b0 : psel;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int waits,
                          input logic [DW-1:0] rdata, input logic err,
                          input bit exp_tmo, input bit hold, output int acc);
    bit got;
    exp_t e;
    bus_t b;
    comp_t c;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("cmd_accept_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    b.wr = wr; b.addr = addr; b.wdata = wdata;
    c.waits = waits; c.rdata = rdata; c.err = err;
    e.acc = acc;
    if (exp_tmo) begin
      e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1; e.lat = -1;
    end else begin
      e.rdata = wr ? '0 : rdata; e.err = err; e.tmo = 1'b0; e.lat = 3 + waits;
    end
    bus_q.push_back(b);
    comp_q.push_back(c);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset_mid_transfer();
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    bus_q.delete();
    comp_q.delete();
    @(negedge clk);
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc1, acc2;
    logic wr, er;
    logic [DW-1:0] d;
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = APB_BASE_ADDR;
    cmd_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);

    // Reset state, with a command held during reset.
    check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    check("reset_psel", 64'(psel), 64'd0);
    check("reset_penable", 64'(penable), 64'd0);
    check("reset_pwrite", 64'(pwrite), 64'd0);
    check("reset_paddr", 64'(paddr), 64'd0);
    check("reset_pwdata", 64'(pwdata), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_rsp_timeout", 64'(rsp_timeout), 64'd0);
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Zero-wait write.
    send_cmd(1'b1, APB_BASE_ADDR, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, 0, 0, acc1);
    check("write_setup_state", 64'(dbg_state), 64'(ST_SETUP));
    drain(20);

    // Wait-state read (4 low-pready ACCESS cycles).
    send_cmd(1'b0, APB_BASE_ADDR + 32'h10, 32'h0BAD_F00D, 4, 32'h1234_5678, 1'b0, 0, 0, acc1);
    drain(30);

    // Error responses: read and write.
    send_cmd(1'b0, APB_BASE_ADDR + 32'h20, 32'h0, 1, 32'hCAFE_0001, 1'b1, 0, 0, acc1);
    drain(20);
    send_cmd(1'b1, APB_BASE_ADDR + 32'h24, 32'h5555_AAAA, 0, 32'hDEAD_BEEF, 1'b1, 0, 0, acc1);
    drain(20);

    // Back-to-back with cmd_valid held.
    send_cmd(1'b1, APB_BASE_ADDR + 32'h30, 32'h1111_2222, 0, 32'h0, 1'b0, 0, 1, acc1);
    send_cmd(1'b0, APB_BASE_ADDR + 32'h34, 32'h0, 0, 32'h3333_4444, 1'b0, 0, 0, acc2);
    check("b2b_accept_in_rsp_cycle", 64'(acc2), 64'(last_rsp_edge));
    check("b2b_spacing", 64'(acc2 - acc1), 64'd3);
    drain(20);
    check("b2b_psel_gap", 64'(last_gap), 64'd1);

    // Randomised traffic, sometimes back-to-back.
    for (int i = 0; i < 12; i++) begin
      wr = 1'($urandom_range(0, 1));
      er = ($urandom_range(0, 3) == 0);
      d  = $urandom;
      send_cmd(wr, APB_BASE_ADDR + 32'($urandom_range(0, 255) << 2), $urandom,
               $urandom_range(0, 3), d, er, 0,
               (i != 11) && ($urandom_range(0, 1) == 1), acc1);
    end
    drain(100);

    // Reset during ACCESS with pready low.
    send_cmd(1'b0, APB_BASE_ADDR + 32'h40, 32'h0, 1000, 32'h7777_7777, 1'b0, 0, 0, acc1);
    @(negedge clk);
    check("rst_test_in_access", 64'(dbg_state), 64'(ST_ACCESS));
    reset_mid_transfer();
    repeat (3) @(negedge clk);
    send_cmd(1'b1, APB_BASE_ADDR + 32'h44, 32'h8888_9999, 2, 32'h0, 1'b0, 0, 0, acc1);
    drain(20);

    // Stuck completer.
`ifdef APB_MASTER_TIMEOUT_EN
    send_cmd(1'b0, APB_BASE_ADDR + 32'h50, 32'h0, 1000, 32'h4242_4242, 1'b0, 1, 0, acc1);
    drain(40);
    check("tmo_back_to_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("tmo_cmd_ready", 64'(cmd_ready), 64'd1);
`else
    send_cmd(1'b0, APB_BASE_ADDR + 32'h50, 32'h0, 1000, 32'h4242_4242, 1'b0, 0, 0, acc1);
    repeat (100) @(negedge clk);
    check("stuck_psel", 64'(psel), 64'd1);
    check("stuck_penable", 64'(penable), 64'd1);
    check("stuck_state", 64'(dbg_state), 64'(ST_ACCESS));
    check("stuck_no_rsp", 64'(exp_q.size()), 64'd1);
    reset_mid_transfer();
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
